set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Sequential bit-scan stage placed directly downstream of the combinational trailing-zero counter. It accepts one DATA_WIDTH-bit word through a valid/ready handshake and emits the index of every set bit, LSB first, one index per beat. Each beat uses the trailing-zero count of the residual word, then clears the lowest set bit. Typical consumers are free-list allocators, interrupt-pending scanners and sparse-mask walkers.

## Interface
- DATA_WIDTH, 32: input word width; power of two, at least 2.
- IDX_W, $clog2(DATA_WIDTH)+1: derived index width, wide enough to hold the value DATA_WIDTH.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  word to scan.
- out_valid  out  1  out_index / out_last / out_empty are valid.
- out_ready  in  1  downstream accepts the current beat.
- out_index  out  IDX_W  bit position of the current set bit; DATA_WIDTH for an all-zero word.
- out_last  out  1  current beat is the final beat of the word.
- out_empty  out  1  the word had no set bits; this is a single beat with out_last=1.
- busy  out  1  a word is held (state EMIT).

## Operation
- Registers:
  - state: IDLE or EMIT.
  - resid: DATA_WIDTH bits.
  - zero_word: 1 bit.
- Combinational outputs, all derived from registers only:
  - in_ready = (state==IDLE).
  - out_valid = (state==EMIT).
  - busy = out_valid.
  - out_index = trailing-zero count of resid, computed as in the trailing-zero stage. It equals DATA_WIDTH when resid==0.
  - out_last = ((resid & (resid-1)) == 0).
  - out_empty = zero_word.
- IDLE:
  - If in_valid is high, the word is accepted.
  - resid <= in_data.
  - zero_word <= (in_data==0).
  - state <= EMIT.
  - Otherwise state and resid hold.
- EMIT with out_ready high (beat taken):
  - resid <= resid & (resid-1), which clears the lowest set bit.
  - If out_last is high, state <= IDLE and zero_word <= 0.
- EMIT with out_ready low: all registers hold, so out_index, out_last and out_empty are stable until the beat is taken.
- A word with k≥1 set bits produces exactly k beats, in strictly increasing index order. Only the k-th beat has out_last high.
- A zero word produces exactly one beat: out_index=DATA_WIDTH, out_last=1, out_empty=1.
- No word is dropped, and no beat is duplicated or reordered.
- in_valid with in_ready low has no effect. The upstream stage must hold in_data until it sees in_ready high.

## Timing
- Reset (rst_n low at a rising edge), applied in any state including mid-word:
  - state=IDLE, resid=0, zero_word=0.
  - The partially emitted word is discarded.
  - The cycle after reset: out_valid=0, busy=0, in_ready=1, out_last=1, out_empty=0, out_index=DATA_WIDTH (don't-care while out_valid=0).
- In the reset cycle itself, handshakes are ignored: an in_valid/in_ready or out_valid/out_ready coincidence while rst_n is low is not a transfer.
- Latency: a word accepted at edge N gives out_valid high during cycle N+1, carrying the first index.
- Throughput: one beat per cycle while out_ready is held high.
- One idle cycle (in_ready high) separates words. A word with k set bits occupies the block for max(k,1)+1 cycles when there is no backpressure.
- There are no combinational paths from in_valid or out_ready to any output.
- Edge cases:
  - resid with only the MSB set: out_index=DATA_WIDTH-1, out_last=1.
  - All-ones word: DATA_WIDTH beats, indices 0..DATA_WIDTH-1.

## Test plan
- Sparse word: in_data=0x00000012, out_ready=1. Required: accept at edge N; cycle N+1 index=1, last=0; cycle N+2 index=4, last=1; cycle N+3 in_ready=1.
- Zero word: in_data=0x00000000. Required: one beat with index=32, last=1, empty=1; then return to IDLE.
- Backpressure: in_data=0x80000001, out_ready low for 3 cycles at each beat. Required: index=0 is held stable for 4 cycles and is then taken; index=31 with last=1 follows; there are exactly 2 beats.
- Dense word: in_data=0xFFFFFFFF, out_ready=1. Required: 32 consecutive beats with indices 0..31; only index 31 has last=1; in_ready stays low for 32 cycles after accept.
- Reset mid-word: load 0x0000F000; after the beat index=12 is taken, drive rst_n low for 1 cycle. Required: next cycle out_valid=0, in_ready=1, busy=0; a new word 0x00000004 then yields a single beat index=2, last=1.
- Back-to-back words: in_valid held high with 0x3, then 0x8, random out_ready. Required: beat sequence 0, 1(last), 3(last); the second word is accepted only in the IDLE cycle after the last beat of the first.

Source files
------------

// File: rtl/set_bit_iterator_if.sv
// Handshake bundle for set_bit_iterator: word input channel and index output channel.
// Both channels use valid/ready; a transfer happens on a rising clk edge where both are high.
interface set_bit_iterator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DATA_WIDTH) + 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic                  out_last;
    logic                  out_empty;
    logic                  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_empty, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_last, out_empty, busy
    );
endinterface

// File: rtl/set_bit_iterator.sv
// Walks the set bits of one accepted word, emitting one index per beat, LSB first.
// A zero word yields a single beat with index DATA_WIDTH and out_empty set.
module set_bit_iterator #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    set_bit_iterator_if.slave bus,
    output logic              dbg_state
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] resid_q, resid_d;
    logic                  zero_word_q, zero_word_d;
    logic [DATA_WIDTH-1:0] resid_clr;
    logic [IDX_W-1:0]      tz_count;
    logic                  last_bit;

    // Lowest set bit wins; an empty residue reports DATA_WIDTH.
    always_comb begin
        tz_count = IDX_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (resid_q[i]) begin
                tz_count = IDX_W'(i);
            end
        end
    end

    always_comb begin
        resid_clr = resid_q & (resid_q - ONE);
        last_bit  = (resid_clr == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            resid_q     <= '0;
            zero_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resid_q     <= resid_d;
            zero_word_q <= zero_word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_EMIT;
            ST_EMIT: if (bus.out_ready && last_bit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resid_d     = resid_q;
        zero_word_d = zero_word_q;
        if (state_q == ST_IDLE && bus.in_valid) begin
            resid_d     = bus.in_data;
            zero_word_d = (bus.in_data == '0);
        end else if (state_q == ST_EMIT && bus.out_ready) begin
            resid_d = resid_clr;
            if (last_bit) begin
                zero_word_d = 1'b0;
            end
        end
    end

    // Outputs come from registers only, so no input-to-output combinational path exists.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_EMIT);
        bus.busy      = (state_q == ST_EMIT);
        bus.out_index = tz_count;
        bus.out_last  = last_bit;
        bus.out_empty = zero_word_q;
        dbg_state     = (state_q == ST_EMIT);
    end
endmodule

// File: tb/tb_set_bit_iterator.sv
// Directed bench for set_bit_iterator; inputs driven and outputs sampled on the falling edge.
module tb_set_bit_iterator;
  localparam int DW = 32;
  localparam int IW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];
  logic exp_last_q[$];

  always #5 clk = ~clk;

  set_bit_iterator_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus ();

  set_bit_iterator #(.DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h5;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL reset_out_last got %0b want 1", bus.out_last); end
    checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL reset_out_empty got %0b want 0", bus.out_empty); end
    checks++; if (bus.out_index !== IW'(DW)) begin errors++; $display("FAIL reset_out_index got %0d want %0d", bus.out_index, DW); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0b want 0", dbg_state); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_sparse();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0000_0012;
    bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sparse_ready got %0b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== IW'(1) || bus.out_last !== 1'b0)
      begin errors++; $display("FAIL sparse_beat0 got v=%0b i=%0d l=%0b want v=1 i=1 l=0", bus.out_valid, bus.out_index, bus.out_last); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== IW'(4) || bus.out_last !== 1'b1)
      begin errors++; $display("FAIL sparse_beat1 got v=%0b i=%0d l=%0b want v=1 i=4 l=1", bus.out_valid, bus.out_index, bus.out_last); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL sparse_idle got rdy=%0b v=%0b want rdy=1 v=0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_zero();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== IW'(DW) || bus.out_last !== 1'b1 || bus.out_empty !== 1'b1)
      begin errors++; $display("FAIL zero_beat got v=%0b i=%0d l=%0b e=%0b want v=1 i=32 l=1 e=1",
                               bus.out_valid, bus.out_index, bus.out_last, bus.out_empty); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_empty !== 1'b0)
      begin errors++; $display("FAIL zero_idle got v=%0b rdy=%0b e=%0b want v=0 rdy=1 e=0", bus.out_valid, bus.in_ready, bus.out_empty); end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] idx_tab [2];
    idx_tab[0] = IW'(0);
    idx_tab[1] = IW'(31);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h8000_0001;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== idx_tab[b] || bus.out_last !== (b == 1) || bus.out_empty !== 1'b0)
          begin errors++; $display("FAIL bp_beat%0d_cyc%0d got v=%0b i=%0d l=%0b want v=1 i=%0d l=%0b",
                                   b, c, bus.out_valid, bus.out_index, bus.out_last, idx_tab[b], (b == 1)); end
        if (c == 3) bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
      end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got v=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_dense();
    bus.in_valid = 1'b1;
    bus.in_data = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== IW'(i) || bus.out_last !== (i == DW - 1) || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL dense_beat%0d got v=%0b i=%0d l=%0b rdy=%0b want v=1 i=%0d l=%0b rdy=0",
                                 i, bus.out_valid, bus.out_index, bus.out_last, bus.in_ready, i, (i == DW - 1)); end
      @(negedge clk);
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dense_idle got rdy=%0b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0000_F000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_index !== IW'(12)) begin errors++; $display("FAIL mid_first got i=%0d want 12", bus.out_index); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL mid_reset got v=%0b rdy=%0b busy=%0b want v=0 rdy=1 busy=0", bus.out_valid, bus.in_ready, bus.busy); end
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0000_0004;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== IW'(2) || bus.out_last !== 1'b1)
      begin errors++; $display("FAIL mid_new_word got v=%0b i=%0d l=%0b want v=1 i=2 l=1", bus.out_valid, bus.out_index, bus.out_last); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_single_beat got v=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int sent;
    bit acc;
    logic [IW-1:0] exp_idx;
    logic exp_last;
    int budget;
    exp_q.delete();
    exp_last_q.delete();
    exp_q.push_back(IW'(0)); exp_last_q.push_back(1'b0);
    exp_q.push_back(IW'(1)); exp_last_q.push_back(1'b1);
    exp_q.push_back(IW'(3)); exp_last_q.push_back(1'b1);
    sent = 0;
    acc = 1'b0;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h3;
    while ((exp_q.size() != 0 || bus.in_valid || bus.out_valid) && budget < 200) begin
      if (acc) begin
        sent++;
        if (sent == 1) bus.in_data = 32'h8;
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat got i=%0d want none", bus.out_index);
        end else begin
          exp_idx = exp_q.pop_front();
          exp_last = exp_last_q.pop_front();
          if (bus.out_index !== exp_idx || bus.out_last !== exp_last)
            begin errors++; $display("FAIL b2b_beat got i=%0d l=%0b want i=%0d l=%0b", bus.out_index, bus.out_last, exp_idx, exp_last); end
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc && sent == 1) begin
        checks++;
        if (exp_q.size() != 1 || bus.out_valid !== 1'b0)
          begin errors++; $display("FAIL b2b_second_accept got pending=%0d v=%0b want pending=1 v=0", exp_q.size(), bus.out_valid); end
      end
      @(negedge clk);
      budget++;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (budget >= 200 || exp_q.size() != 0)
      begin errors++; $display("FAIL b2b_timeout got pending=%0d cycles=%0d want pending=0", exp_q.size(), budget); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sparse();
    test_zero();
    test_backpressure();
    test_dense();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
